// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon permutation: one full round (pC, pS, pL) per clock over a
// 320-bit state, with start/done handshake for p12, p8 and p6.

module ascon_constant_add (
   input  logic [4:0][63:0] state_i,
   input  logic [3:0]       round_i,
   output logic [4:0][63:0] state_o
);
   logic [7:0] round_const;

   assign round_const = {4'hF - round_i, round_i};

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_o          = state_i;
      state_o[2][7:0]  = state_i[2][7:0] ^ round_const;
   end
endmodule

module ascon_substitution (
   input  logic [4:0][63:0] state_i,
   output logic [4:0][63:0] state_o
);
   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] t0, t1, t2, t3, t4;
   logic [63:0] b0, b1, b2, b3, b4;

   // Bit-sliced form of the 5-bit S-box; each bit column is one S-box instance.
   assign a0 = state_i[0] ^ state_i[4];
   assign a1 = state_i[1];
   assign a2 = state_i[2] ^ state_i[1];
   assign a3 = state_i[3];
   assign a4 = state_i[4] ^ state_i[3];

   assign t0 = ~a0 & a1;
   assign t1 = ~a1 & a2;
   assign t2 = ~a2 & a3;
   assign t3 = ~a3 & a4;
   assign t4 = ~a4 & a0;

   assign b0 = a0 ^ t1;
   assign b1 = a1 ^ t2;
   assign b2 = a2 ^ t3;
   assign b3 = a3 ^ t4;
   assign b4 = a4 ^ t0;

   assign state_o[0] = b0 ^ b4;
   assign state_o[1] = b1 ^ b0;
   assign state_o[2] = ~b2;
   assign state_o[3] = b3 ^ b2;
   assign state_o[4] = b4;
endmodule

module ascon_diffusion (
   input  logic [4:0][63:0] state_i,
   output logic [4:0][63:0] state_o
);
   logic [63:0] x0, x1, x2, x3, x4;

   assign x0 = state_i[0];
   assign x1 = state_i[1];
   assign x2 = state_i[2];
   assign x3 = state_i[3];
   assign x4 = state_i[4];

   // Rotate right by n is {x[n-1:0], x[63:n]}.
   assign state_o[0] = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
   assign state_o[1] = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
   assign state_o[2] = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
   assign state_o[3] = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
   assign state_o[4] = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
endmodule

module ascon_permutation_iter #(
   parameter int NB_ROUND_MAX = 12
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [4:0][63:0] state_i,
   output logic [4:0][63:0] state_o,
   output logic [3:0]       round_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [3:0] LAST_ROUND  = 4'(NB_ROUND_MAX - 1);
   localparam logic [3:0] START_P12   = 4'(NB_ROUND_MAX - 12);
   localparam logic [3:0] START_P8    = 4'(NB_ROUND_MAX - 8);
   localparam logic [3:0] START_P6    = 4'(NB_ROUND_MAX - 6);

   logic [0:0]       fsm_q;
   logic [4:0][63:0] state_q;
   logic [3:0]       round_q;
   logic             busy_q;
   logic             done_q;

   logic [4:0][63:0] after_const;
   logic [4:0][63:0] after_sbox;
   logic [4:0][63:0] after_linear;
   logic [3:0]       start_round;

   ascon_constant_add u_constant_add (
      .state_i (state_q),
      .round_i (round_q),
      .state_o (after_const)
   );

   ascon_substitution u_substitution (
      .state_i (after_const),
      .state_o (after_sbox)
   );

   ascon_diffusion u_diffusion (
      .state_i (after_sbox),
      .state_o (after_linear)
   );

   // Reserved mode 2'b11 runs the full permutation like p12.
   always_comb begin
      start_round = START_P12;
      case (mode_i)
         2'b01:   start_round = START_P8;
         2'b10:   start_round = START_P6;
         default: start_round = START_P12;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q   <= IDLE;
         // NOTE: the wide state register is reset deliberately: state_o must read zero after reset.
         state_q <= '0;
         round_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            IDLE: begin
               if (start_i) begin
                  state_q <= state_i;
                  round_q <= start_round;
                  busy_q  <= 1'b1;
                  fsm_q   <= RUN;
               end
            end
            RUN: begin
               state_q <= after_linear;
               if (round_q == LAST_ROUND) begin
                  round_q <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  fsm_q   <= IDLE;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign state_o = state_q;
   assign round_o = round_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Directed bench for ascon_permutation_iter; expected states come from a
// table-driven S-box model with hand-listed round constants.

module tb_ascon_permutation_iter;
   typedef logic [4:0][63:0] state_t;

   localparam logic [4:0] SBOX [0:31] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   localparam logic [7:0] RC [0:11] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
      8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
   };

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic [1:0] mode_i;
   state_t     state_i;
   state_t     state_o;
   logic [3:0] round_o;
   logic       busy_o;
   logic       done_o;

   int checks   = 0;
   int failures = 0;

   ascon_permutation_iter #(.NB_ROUND_MAX(12)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .start_i (start_i),
      .mode_i  (mode_i),
      .state_i (state_i),
      .state_o (state_o),
      .round_o (round_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic state_t model_round(input state_t s, input logic [7:0] c);
      state_t t;
      logic [4:0] idx;
      logic [4:0] o;
      s[2] = s[2] ^ {56'h0, c};
      for (int col = 0; col < 64; col++) begin
         idx = {s[0][col], s[1][col], s[2][col], s[3][col], s[4][col]};
         o   = SBOX[idx];
         t[0][col] = o[4];
         t[1][col] = o[3];
         t[2][col] = o[2];
         t[3][col] = o[1];
         t[4][col] = o[0];
      end
      s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
      s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
      s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
      s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
      s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
      return s;
   endfunction

   // Starts a run at the current negedge and returns at the negedge of the done cycle.
   task automatic run_perm(input string tag, input logic [1:0] mode, input state_t s_in,
                           input bit poke, output state_t result);
      int     n;
      int     r0;
      state_t exp;
      case (mode)
         2'b01:   n = 8;
         2'b10:   n = 6;
         default: n = 12;
      endcase
      r0 = 12 - n;
      start_i = 1'b1;
      mode_i  = mode;
      state_i = s_in;
      @(negedge clock_i);
      start_i = 1'b0;
      exp = s_in;
      check($sformatf("%s_load_state", tag), state_o, exp);
      check($sformatf("%s_first_round", tag), 320'(round_o), 320'(r0));
      check($sformatf("%s_busy_start", tag), 320'(busy_o), 320'd1);
      for (int k = 0; k < n; k++) begin
         if (poke && k == 2) begin
            start_i = 1'b1;
            mode_i  = 2'b10;
            state_i = ~s_in;
         end
         @(negedge clock_i);
         start_i = 1'b0;
         exp = model_round(exp, RC[r0 + k]);
         check($sformatf("%s_state_r%0d", tag, r0 + k), state_o, exp);
         if (k < n - 1) begin
            check($sformatf("%s_round_k%0d", tag, k), 320'(round_o), 320'(r0 + k + 1));
            check($sformatf("%s_busy_k%0d", tag, k), 320'(busy_o), 320'd1);
            check($sformatf("%s_done_early_k%0d", tag, k), 320'(done_o), 320'd0);
         end else begin
            check($sformatf("%s_round_wrap", tag), 320'(round_o), 320'd0);
            check($sformatf("%s_busy_end", tag), 320'(busy_o), 320'd0);
            check($sformatf("%s_done", tag), 320'(done_o), 320'd1);
         end
      end
      result = exp;
   endtask

   initial begin
      state_t zero_s;
      state_t a_s;
      state_t b_s;
      state_t res;
      state_t res_p12_a;
      int     done_seen;

      zero_s = '0;
      a_s = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
             64'h8000000000000001, 64'h80400c0600000000};
      b_s = {64'hdeadbeefcafef00d, 64'h0000000000000000, 64'hffffffffffffffff,
             64'h5555aaaa5555aaaa, 64'h1122334455667788};

      reset_i = 1'b1;
      start_i = 1'b0;
      mode_i  = 2'b00;
      state_i = a_s;
      @(negedge clock_i);
      @(negedge clock_i);
      check("reset_state", state_o, '0);
      check("reset_round", 320'(round_o), 320'd0);
      check("reset_busy", 320'(busy_o), 320'd0);
      check("reset_done", 320'(done_o), 320'd0);
      reset_i = 1'b0;
      @(negedge clock_i);

      // p12 on the zero state, then hold for 10+ cycles.
      run_perm("p12_zero", 2'b00, zero_s, 1'b0, res);
      for (int i = 0; i < 12; i++) begin
         @(negedge clock_i);
         check($sformatf("hold_state_%0d", i), state_o, res);
         check($sformatf("hold_done_%0d", i), 320'(done_o), 320'd0);
         check($sformatf("hold_round_%0d", i), 320'(round_o), 320'd0);
      end

      // p8 then p12 back-to-back: the second start lands in the done cycle.
      run_perm("p8_a", 2'b01, a_s, 1'b0, res);
      run_perm("b2b_p12_b", 2'b00, b_s, 1'b0, res);
      @(negedge clock_i);
      check("b2b_done_single", 320'(done_o), 320'd0);

      run_perm("p6_a", 2'b10, a_s, 1'b0, res);
      @(negedge clock_i);

      // Start pulse during a busy p12 run must be ignored.
      run_perm("p12_poke", 2'b00, a_s, 1'b1, res_p12_a);
      @(negedge clock_i);

      run_perm("mode11", 2'b11, a_s, 1'b0, res);
      check("mode11_vs_p12", res, res_p12_a);
      @(negedge clock_i);

      // Reset at round 5 discards the run with no done pulse.
      start_i = 1'b1;
      mode_i  = 2'b00;
      state_i = zero_s;
      @(negedge clock_i);
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clock_i);
      check("mid_round5", 320'(round_o), 320'd5);
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      check("mid_reset_state", state_o, '0);
      check("mid_reset_round", 320'(round_o), 320'd0);
      check("mid_reset_busy", 320'(busy_o), 320'd0);
      done_seen = 0;
      if (done_o) done_seen++;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock_i);
         if (done_o) done_seen++;
      end
      check("mid_reset_no_done", 320'(done_seen), 320'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
